msg_asm: RTL and testbench
==========================

Name: msg_asm

Overview:
Message assembler: receive direction of the controller/UART message path. Collects WORDS_PER_PACKET consecutive words from the UART receiver and packs them into one wide message for the controller. Word order matches the transmit path: first word received lands in data_out[WORD_SIZE-1:0]. The assembled message is held stable until the controller acknowledges it.

Parameters:
WORD_SIZE, 8, bits per UART word
WORDS_PER_PACKET, 4, words per message (>=2)
TIMEOUT_CYCLES, 1000000, inter-word gap limit in clk cycles; used only with MSG_ASM_TIMEOUT_EN
Derived: CTR_WIDTH = $clog2(WORDS_PER_PACKET); OUTPUT_WIDTH = WORD_SIZE*WORDS_PER_PACKET

Ports:
clk  input  1  system clock, all logic on rising edge
n_reset  input  1  asynchronous active-low reset
data_in  input  WORD_SIZE  word from UART receiver
data_in_valid  input  1  one-cycle strobe; data_in valid this cycle
data_out  output  OUTPUT_WIDTH  assembled message, word i at [(i+1)*WORD_SIZE-1 : i*WORD_SIZE]
data_out_valid  output  1  message complete and held
data_out_ack  input  1  controller consumes message; sampled only while data_out_valid=1
ready  output  1  high in SM_RX (accepting words)
overrun  output  1  sticky: word(s) dropped while a message was held

Behaviour:
- Reset (async assert, sync-safe deassert into logic): state=SM_RX, ctr=0, data_out=0, data_out_valid=0, overrun=0, ready=1.
- States: SM_RX (collecting), SM_HOLD (message presented).
- SM_RX: on data_in_valid, word slot ctr <= data_in, ctr <= ctr+1. Words are written in place; other slots untouched.
- SM_RX, data_in_valid with ctr==WORDS_PER_PACKET-1: write final slot, ctr <= 0, state <= SM_HOLD. data_out_valid rises the cycle after the last strobe (latency 1 clk from final word to valid).
- SM_HOLD: data_out and data_out_valid held constant; ready=0.
- SM_HOLD, data_out_ack=1: state <= SM_RX, data_out_valid <= 0 next cycle, overrun <= 0. data_out keeps its last value (not cleared).
- SM_HOLD, data_in_valid without ack: word dropped, overrun <= 1, ctr unchanged.
- SM_HOLD, data_in_valid and data_out_ack same cycle: ack taken, word accepted as slot 0 of next message (ctr <= 1), overrun cleared; no drop.
- data_out_ack while in SM_RX: ignored.
- data_in_valid on consecutive cycles: each accepted; no minimum spacing.
- ctr never exceeds WORDS_PER_PACKET-1; non-power-of-2 WORDS_PER_PACKET supported, unused ctr codes unreachable.
- Reset mid-message: partial words discarded, outputs to reset values immediately.

Optional Feature:
MSG_ASM_TIMEOUT_EN
- Defined: gap counter (width $clog2(TIMEOUT_CYCLES+1)) cleared on every accepted word, increments each cycle in SM_RX while ctr!=0. On reaching TIMEOUT_CYCLES: ctr <= 0, gap counter cleared, partial message abandoned (resynchronises after a lost byte). A word arriving in the same cycle as expiry is taken as slot 0 (ctr <= 1). No counting in SM_HOLD or with ctr==0.
- Not defined: no gap counter; partial message waits indefinitely; TIMEOUT_CYCLES unused.

Test Plan:
- Defaults, words 0x11,0x22,0x33,0x44 one per 10 clk -> data_out_valid high 1 clk after 0x44, data_out=0x44332211, ready=0; ack -> valid low next clk, ready=1.
- Back-to-back strobes 0xA0..0xA3 on 4 consecutive cycles -> data_out=0xA3A2A1A0, valid on 5th cycle.
- Message held, send 0x55 without ack -> overrun=1, data_out unchanged; ack -> overrun=0, next message starts at slot 0.
- Held message, ack and data_in_valid(0x77) same cycle -> no overrun; then 0x88,0x99,0xAA -> data_out=0xAA998877.
- Assert n_reset low after 2 words -> all outputs reset immediately; 4 new words then assemble correctly from slot 0.
- MSG_ASM_TIMEOUT_EN, TIMEOUT_CYCLES=16: send 0x01,0x02, wait 16 clk, send 0x10,0x20,0x30,0x40 -> data_out=0x40302010; without macro same stimulus -> data_out=0x20100201.

Source files
------------

// File: rtl/msg_asm.sv
// -----------------------------------------------------------------------------
// msg_asm -- message assembler, receive side of the controller/UART path.
//
// Packs WORDS_PER_PACKET consecutive UART words into one wide message. The
// first word received lands in data_out[WORD_SIZE-1:0]. The finished message
// is held until the controller acks it. Words arriving while a message is
// held (and not acked in the same cycle) are dropped and flagged on overrun.
//
// Ports:
//   clk            in   system clock, rising edge
//   n_reset        in   async active-low reset
//   data_in        in   [WORD_SIZE] word from UART receiver
//   data_in_valid  in   one-cycle strobe qualifying data_in
//   data_out       out  [WORD_SIZE*WORDS_PER_PACKET] assembled message
//   data_out_valid out  message complete and held
//   data_out_ack   in   controller consumes message (only seen while valid)
//   ready          out  accepting words
//   overrun        out  sticky: word(s) dropped while a message was held
//
// Optional feature macro: MSG_ASM_TIMEOUT_EN
//   Adds an inter-word gap counter; a partial message idle for
//   TIMEOUT_CYCLES clocks is abandoned so the assembler resynchronises
//   after a lost word. Without it a partial message waits indefinitely.
// -----------------------------------------------------------------------------
module msg_asm #(
  parameter int WORD_SIZE        = 8,
  parameter int WORDS_PER_PACKET = 4,
  parameter int TIMEOUT_CYCLES   = 1000000
) (
  input  logic                                  clk,
  input  logic                                  n_reset,
  input  logic [WORD_SIZE-1:0]                  data_in,
  input  logic                                  data_in_valid,
  output logic [WORD_SIZE*WORDS_PER_PACKET-1:0] data_out,
  output logic                                  data_out_valid,
  input  logic                                  data_out_ack,
  output logic                                  ready,
  output logic                                  overrun
);

  localparam int CTR_WIDTH    = $clog2(WORDS_PER_PACKET);
  localparam int OUTPUT_WIDTH = WORD_SIZE * WORDS_PER_PACKET;

  typedef enum logic {SM_RX, SM_HOLD} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CTR_WIDTH-1:0]    r_ctr, w_slot;
  logic [OUTPUT_WIDTH-1:0] r_data;
  logic                    r_ovr;
  logic                    w_accept, w_last, w_drop;
  logic                    w_expire;

`ifdef MSG_ASM_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] r_gap;

  // Only a partially filled message in SM_RX can time out.
  assign w_expire = (r_state == SM_RX) && (r_ctr != '0) &&
                    (r_gap == GAP_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                           r_gap <= '0;
    else if (w_accept || w_expire)          r_gap <= '0;
    else if (r_state == SM_RX && r_ctr != '0) r_gap <= r_gap + 1'b1;
  end
`else
  assign w_expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= SM_RX;
    else          r_state <= w_state_nxt;
  end

  // Next state / accept decode. A word coinciding with a timeout expiry is
  // written as slot 0 of a fresh message. In SM_HOLD r_ctr is always 0, so an
  // ack+word cycle naturally lands the word in slot 0.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_slot      = w_expire ? '0 : r_ctr;
    w_last      = (w_slot == CTR_WIDTH'(WORDS_PER_PACKET - 1));
    case (r_state)
      SM_RX: begin
        w_accept = data_in_valid;
        if (data_in_valid && w_last) w_state_nxt = SM_HOLD;
      end
      SM_HOLD: begin
        if (data_out_ack) begin
          w_state_nxt = SM_RX;
          w_accept    = data_in_valid;
        end else begin
          w_drop      = data_in_valid;
        end
      end
      default: w_state_nxt = SM_RX;
    endcase
  end

  // Datapath: slots written in place, untouched slots keep old contents.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_ctr  <= '0;
      r_data <= '0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data[w_slot*WORD_SIZE +: WORD_SIZE] <= data_in;
        r_ctr <= w_last ? '0 : w_slot + 1'b1;
      end else if (w_expire) begin
        r_ctr <= '0;
      end
      if (w_drop)                                  r_ovr <= 1'b1;
      else if (r_state == SM_HOLD && data_out_ack) r_ovr <= 1'b0;
    end
  end

  assign data_out       = r_data;
  assign data_out_valid = (r_state == SM_HOLD);
  assign ready          = (r_state == SM_RX);
  assign overrun        = r_ovr;

endmodule

// File: tb/tb_msg_asm.sv
// -----------------------------------------------------------------------------
// tb_msg_asm -- self-checking bench for msg_asm (defaults, TIMEOUT_CYCLES=16).
// A behavioural model tracks slots/hold/overrun; completed messages are queued
// and popped by a monitor when data_out_valid rises.
// -----------------------------------------------------------------------------
module tb_msg_asm;
  localparam int WS  = 8;
  localparam int WPP = 4;
  localparam int TO  = 16;
  localparam int OW  = WS * WPP;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic [WS-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic [OW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ack = 1'b0;
  logic          ready;
  logic          overrun;

  msg_asm #(.WORD_SIZE(WS), .WORDS_PER_PACKET(WPP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_reset(n_reset), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_out(data_out),
    .data_out_valid(data_out_valid), .data_out_ack(data_out_ack),
    .ready(ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] m_msg = '0;
  int            m_ctr = 0;
  bit            m_held = 0;
  bit            m_ovr = 0;

  // Monitor: each rising edge of data_out_valid consumes one expected message.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (n_reset && data_out_valid && !prev_v) begin
      if (exp_q.size() == 0) chk("unexpected_msg", data_out, '1);
      else                   chk("msg", data_out, exp_q.pop_front());
    end
    prev_v <= n_reset ? data_out_valid : 1'b0;
  end

  task automatic check_state(input string tag);
    chk({tag, "_valid"},   data_out_valid, m_held);
    chk({tag, "_ready"},   ready, !m_held);
    chk({tag, "_overrun"}, overrun, m_ovr);
    chk({tag, "_data"},    data_out, m_msg);
  endtask

  task automatic send(input logic [WS-1:0] w, input bit ack);
    data_in = w; data_in_valid = 1'b1; data_out_ack = ack;
    if (m_held && !ack) m_ovr = 1;
    else begin
      if (m_held) begin m_held = 0; m_ovr = 0; end
      m_msg[m_ctr*WS +: WS] = w;
      m_ctr++;
      if (m_ctr == WPP) begin m_ctr = 0; m_held = 1; exp_q.push_back(m_msg); end
    end
    @(posedge clk); #1;
    data_in_valid = 1'b0; data_out_ack = 1'b0;
  endtask

  task automatic ack();
    data_out_ack = 1'b1;
    if (m_held) begin m_held = 0; m_ovr = 0; end
    @(posedge clk); #1;
    data_out_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
`ifdef MSG_ASM_TIMEOUT_EN
    if (n >= TO && !m_held) m_ctr = 0;
`endif
  endtask

  initial begin
    #12;
    check_state("reset");
    n_reset = 1'b1;
    @(posedge clk); #1;

    // Spaced words
    send(8'h11, 0); idle(9); send(8'h22, 0); idle(9);
    send(8'h33, 0); idle(9); send(8'h44, 0);
    check_state("spaced");
    chk("spaced_word", data_out, 32'h44332211);
    idle(3); check_state("spaced_hold");
    ack(); check_state("spaced_ack");

    // Ack ignored in RX
    ack(); check_state("ack_in_rx");

    // Back-to-back
    send(8'hA0, 0); send(8'hA1, 0); send(8'hA2, 0);
    chk("b2b_not_yet", data_out_valid, 1'b0);
    send(8'hA3, 0);
    check_state("b2b");
    chk("b2b_word", data_out, 32'hA3A2A1A0);

    // Overrun while held
    send(8'h55, 0); check_state("ovr");
    chk("ovr_word", data_out, 32'hA3A2A1A0);
    ack(); check_state("ovr_ack");
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    chk("after_ovr", data_out, 32'h04030201);

    // Ack and word same cycle
    send(8'h55, 0); check_state("ovr2");
    send(8'h77, 1); check_state("ackword");
    send(8'h88, 0); send(8'h99, 0); send(8'hAA, 0);
    check_state("ackword_msg");
    chk("ackword_word", data_out, 32'hAA998877);
    ack();

    // Reset mid-message
    send(8'hDE, 0); send(8'hAD, 0);
    #2 n_reset = 1'b0;
    #1;
    m_msg = '0; m_ctr = 0; m_held = 0; m_ovr = 0;
    check_state("midreset");
    @(posedge clk); #3 n_reset = 1'b1;
    @(posedge clk); #1;
    send(8'hC0, 0); send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0);
    check_state("post_reset");
    chk("post_reset_word", data_out, 32'hC3C2C1C0);
    ack();

    // Gap / timeout stimulus
    send(8'h01, 0); send(8'h02, 0); idle(20);
    send(8'h10, 0); send(8'h20, 0); send(8'h30, 0); send(8'h40, 0);
    check_state("gap");
`ifdef MSG_ASM_TIMEOUT_EN
    chk("gap_word", data_out, 32'h40302010);
`else
    chk("gap_word", data_out, 32'h20100201);
`endif
    ack(); check_state("end");

    idle(3);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1);
  end
endmodule
